// File: rtl/add_loader_pkg.sv
// Shared types and defaults for the 100-bit adder operand loader.
package add_loader_pkg;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        PRESENT = 2'd2
    } loader_state_t;

    localparam int ADD_WIDTH = 100;
    localparam int ADD_CHUNK = 20;

endpackage

// File: rtl/loader_chunk_reg.sv
// WIDTH-bit operand register written one CHUNK-wide slice at a time; async clear.
module loader_chunk_reg #(
    parameter int WIDTH  = 100,
    parameter int CHUNK  = 20,
    parameter int NCHUNK = WIDTH / CHUNK,
    parameter int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IW-1:0]    idx,
    input  logic [CHUNK-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [NCHUNK-1:0][CHUNK-1:0] q_q;

    // Only the addressed slice moves, so untouched slices stay glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q_q <= '0;
        else if (we)
            q_q[idx] <= d;
    end

    assign q = q_q;

endmodule

// File: rtl/add_operand_loader.sv
// Assembles A/B operands from LSB-first chunks and holds them for the adder.
// Optional `abort` input enabled by defining ADD_LOADER_ABORT_EN.
module add_operand_loader
    import add_loader_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int CHUNK = ADD_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CHUNK-1:0] in_data,
    input  logic             in_cin,
`ifdef ADD_LOADER_ABORT_EN
    input  logic             abort,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             cin
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    loader_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cin_q, cin_d;
    logic          accept, abort_w, we_a, we_b;

`ifdef ADD_LOADER_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD_A;
            cnt_q   <= '0;
            cin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cin_q   <= cin_d;
        end
    end

    // Abort wins over a same-cycle beat; it never touches PRESENT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cin_d   = cin_q;
        case (state_q)
            LOAD_A: begin
                if (abort_w) begin
                    cnt_d = '0;
                end else if (accept) begin
                    if (cnt_q == '0) cin_d = in_cin;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = LOAD_B;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            LOAD_B: begin
                if (abort_w) begin
                    cnt_d   = '0;
                    state_d = LOAD_A;
                end else if (accept) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = PRESENT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            PRESENT: begin
                if (out_ready) state_d = LOAD_A;
            end
            default: begin
                state_d = LOAD_A;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        in_ready  = (state_q != PRESENT);
        out_valid = (state_q == PRESENT);
        we_a      = accept & ~abort_w & (state_q == LOAD_A);
        we_b      = accept & ~abort_w & (state_q == LOAD_B);
    end

    loader_chunk_reg #(.WIDTH(WIDTH), .CHUNK(CHUNK), .NCHUNK(NCHUNK), .IW(CW)) u_reg_a (
        .clk (clk),
        .rst (rst),
        .we  (we_a),
        .idx (cnt_q),
        .d   (in_data),
        .q   (a)
    );

    loader_chunk_reg #(.WIDTH(WIDTH), .CHUNK(CHUNK), .NCHUNK(NCHUNK), .IW(CW)) u_reg_b (
        .clk (clk),
        .rst (rst),
        .we  (we_b),
        .idx (cnt_q),
        .d   (in_data),
        .q   (b)
    );

    assign cin = cin_q;

endmodule

// File: tb/tb_add_operand_loader.sv
// Directed + randomized bench for add_operand_loader against an arithmetic pair model.
module tb_add_operand_loader;

    localparam int W = 100;
    localparam int C = 20;
    localparam int N = W / C;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_cin = 1'b0;
    logic         out_ready = 1'b0;
    logic [C-1:0] in_data = '0;
    logic         in_ready, out_valid, cin;
    logic [W-1:0] a, b;
`ifdef ADD_LOADER_ABORT_EN
    logic         abort = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    add_operand_loader #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cin    (in_cin),
`ifdef ADD_LOADER_ABORT_EN
        .abort     (abort),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .cin       (cin)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: operand value = sum of chunk_k * 2^(C*k).
    function automatic logic [W-1:0] pack(input logic [C-1:0] ch [N]);
        logic [W-1:0] acc = '0;
        for (int k = 0; k < N; k++) acc = acc + (W'(ch[k]) << (k * C));
        return acc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [C-1:0] d, input logic ci);
        in_valid = 1'b1;
        in_data  = d;
        in_cin   = ci;
        chk("in_ready_load", W'(in_ready), W'(1));
        tick();
        in_valid = 1'b0;
        in_data  = C'($urandom);
        in_cin   = 1'($urandom);
    endtask

    // Loads a full pair with up to maxgap idle cycles between beats (none after the last).
    task automatic load(input logic [C-1:0] ca [N], input logic [C-1:0] cb [N],
                        input logic ci, input int maxgap, output int gaps);
        int g;
        gaps = 0;
        for (int k = 0; k < 2 * N; k++) begin
            if (k < N) beat(ca[k], (k == 0) ? ci : 1'($urandom));
            else       beat(cb[k-N], 1'($urandom));
            if (k < 2 * N - 1 && maxgap > 0) begin
                g = $urandom_range(maxgap, 0);
                gaps += g;
                repeat (g) begin
                    tick();
                    chk("no_early_valid", W'(out_valid), W'(0));
                end
            end
        end
        chk("out_valid", W'(out_valid), W'(1));
        chk("in_ready_present", W'(in_ready), W'(0));
        chk("a", a, pack(ca));
        chk("b", b, pack(cb));
        chk("cin", W'(cin), W'(ci));
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("consume_out_valid", W'(out_valid), W'(0));
        chk("consume_in_ready", W'(in_ready), W'(1));
    endtask

    initial begin
        logic [C-1:0] ca [N];
        logic [C-1:0] cb [N];
        logic [W-1:0] ea, eb;
        logic         ci;
        int           gaps, c0;

        // Asynchronous reset mid-cycle, checked before any edge.
        #13 rst = 1'b1;
        #1;
        chk("rst_a", a, '0);
        chk("rst_b", b, '0);
        chk("rst_cin", W'(cin), W'(0));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(1));
        @(negedge clk) rst = 1'b0;
        tick();

        // Wrap case: all-ones A plus B=1 plus cin=1.
        for (int k = 0; k < N; k++) begin
            ca[k] = '1;
            cb[k] = (k == 0) ? C'(1) : '0;
        end
        load(ca, cb, 1'b1, 0, gaps);
        chk("wrap_a_all_ones", a, {W{1'b1}});
        chk("wrap_sum", a + b + W'(cin), W'(1));

        // Back-pressure: inputs ignored and operands frozen while PRESENT.
        ea = pack(ca);
        eb = pack(cb);
        in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_data = C'($urandom);
            in_cin  = 1'($urandom);
            tick();
            chk("bp_in_ready", W'(in_ready), W'(0));
            chk("bp_out_valid", W'(out_valid), W'(1));
            chk("bp_a", a, ea);
            chk("bp_b", b, eb);
            chk("bp_cin", W'(cin), W'(1));
        end
        in_valid = 1'b0;
        consume();
        chk("no_bulk_clear_a", a, ea);

        // Ordering and gaps: A chunk k = k+1, cycle count = beats + idle cycles.
        for (int k = 0; k < N; k++) begin
            ca[k] = C'(k + 1);
            cb[k] = C'($urandom);
        end
        c0 = cyc;
        load(ca, cb, 1'b0, 3, gaps);
        chk("order_cycles", W'(cyc - c0), W'(2 * N + gaps));
        for (int k = 0; k < N; k++) chk("order_chunk", W'(a[k*C +: C]), W'(k + 1));
        consume();

        // Full pair period with out_ready already high.
        for (int k = 0; k < N; k++) begin
            ca[k] = C'($urandom);
            cb[k] = C'($urandom);
        end
        ci = 1'($urandom);
        out_ready = 1'b1;
        c0 = cyc;
        load(ca, cb, ci, 0, gaps);
        tick();
        out_ready = 1'b0;
        chk("period_cycles", W'(cyc - c0), W'(2 * N + 1));
        chk("period_in_ready", W'(in_ready), W'(1));

        // Reset mid-load discards partial operands.
        for (int k = 0; k < 3; k++) beat(C'($urandom), 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_a", a, '0);
        chk("midrst_b", b, '0);
        chk("midrst_in_ready", W'(in_ready), W'(1));
        @(negedge clk) rst = 1'b0;
        tick();
        for (int k = 0; k < N; k++) begin
            ca[k] = C'($urandom);
            cb[k] = C'($urandom);
        end
        load(ca, cb, 1'b1, 1, gaps);
        consume();

`ifdef ADD_LOADER_ABORT_EN
        // Abort on B beat 2: nothing presented, then a clean pair follows.
        eb = b;
        for (int k = 0; k < N; k++) beat(C'($urandom), 1'b0);
        beat(C'($urandom), 1'b0);
        beat(C'($urandom), 1'b0);
        abort = 1'b1;
        beat(C'($urandom), 1'b0);
        abort = 1'b0;
        chk("abort_out_valid", W'(out_valid), W'(0));
        chk("abort_b_chunk2_kept", W'(b[2*C +: C]), W'(eb[2*C +: C]));
        for (int k = 0; k < N; k++) begin
            ca[k] = C'($urandom);
            cb[k] = C'($urandom);
        end
        load(ca, cb, 1'b1, 0, gaps);
        consume();
`endif

        // Randomized pairs with gaps and random consumer delay.
        for (int p = 0; p < 6; p++) begin
            for (int k = 0; k < N; k++) begin
                ca[k] = C'($urandom);
                cb[k] = C'($urandom);
            end
            ci = 1'($urandom);
            load(ca, cb, ci, 2, gaps);
            repeat ($urandom_range(3, 0)) begin
                tick();
                chk("hold_a", a, pack(ca));
                chk("hold_valid", W'(out_valid), W'(1));
            end
            consume();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/add_operand_loader.md
# add_operand_loader

Upstream feeder for the 100-bit ripple-carry adder. It accepts the two operands as narrow LSB-first chunks over a valid/ready stream and assembles them into full-width registers. It then presents `a`, `b` and `cin` to the adder, holding them stable until a downstream consumer accepts them. This lets a narrow bus drive the wide combinational adder without exposing it to partially loaded operands.

## Interface
- `WIDTH`, default 100: operand width; must equal the adder width.
- `CHUNK`, default 20: beat width. `WIDTH` must be an integer multiple of `CHUNK`.
- `NCHUNK`: localparam, `WIDTH/CHUNK` (5 by default).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: beat valid.
- `in_ready` out 1: loader can accept a beat.
- `in_data` in CHUNK: operand chunk.
- `in_cin` in 1: carry-in; sampled only on the first beat of operand A.
- `out_valid` out 1: `a`, `b` and `cin` form a complete pair.
- `out_ready` in 1: consumer accepts the pair.
- `a` out WIDTH: operand A, to the adder.
- `b` out WIDTH: operand B, to the adder.
- `cin` out 1: carry-in, to the adder.

## Operation
- FSM states are LOAD_A, LOAD_B and PRESENT, plus a beat counter `cnt` of width clog2(NCHUNK).
- A beat is accepted when `in_valid & in_ready`.
- `in_ready` = (state != PRESENT), decoded combinationally from the state register.
- `out_valid` = (state == PRESENT).
- **LOAD_A:**
  - An accepted beat writes `a[cnt*CHUNK +: CHUNK]`.
  - If `cnt == 0`, the beat also latches `cin <= in_cin`.
  - When `cnt == NCHUNK-1`: `cnt <= 0`, go to LOAD_B. Otherwise `cnt++`.
- **LOAD_B:**
  - An accepted beat writes `b[cnt*CHUNK +: CHUNK]`.
  - When `cnt == NCHUNK-1`: `cnt <= 0`, go to PRESENT. Otherwise `cnt++`.
- **PRESENT:**
  - `a`, `b` and `cin` are frozen and `in_data` is ignored.
  - On `out_valid & out_ready`, go to LOAD_A.
- Registers are overwritten chunk by chunk, never bulk-cleared, except by reset.
- Idle cycles (`in_valid` = 0) never advance `cnt` or change the state.
- **Reset**, asynchronous at any time including mid-load:
  - state becomes LOAD_A and `cnt` becomes 0;
  - `a`, `b` and `cin` become 0, and `out_valid` becomes 0;
  - `in_ready` is 1 while reset is asserted and afterwards;
  - any partial operands are lost.

## Timing
- Beat acceptance takes one cycle per chunk, with no bubbles required between beats.
- `out_valid` rises on the cycle after the last B beat is accepted (registered).
- If `out_ready` is already 1 at that point, `in_ready` returns high the following cycle.
- Full pair period is 2·NCHUNK + 1 cycles (11 by default).
- `a`, `b` and `cin` change only on accepted beats or on reset. They are glitch-free to the adder for the whole PRESENT interval.
- There is no combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.

## Configuration
- **`ADD_LOADER_ABORT_EN` defined:**
  - adds an input port `abort` (1 bit);
  - in LOAD_A or LOAD_B, `abort` = 1 forces state to LOAD_A and `cnt` to 0 on the next edge;
  - `abort` takes priority over a simultaneous accepted beat, whose data is dropped;
  - register contents are left as-is and no `out_valid` is produced;
  - `abort` is ignored in PRESENT.
- **Not defined:** the port is absent and the FSM has no abort transitions.

## Structure
- Shared package `add_loader_pkg` holds:
  - the state enum `loader_state_t` (LOAD_A, LOAD_B, PRESENT);
  - defaults `ADD_WIDTH` = 100 and `ADD_CHUNK` = 20.
- Sub-module `loader_chunk_reg`: a WIDTH-bit register with a chunk-indexed write (`we`, `idx`, `d`) and async clear. It is instantiated twice, once for `a` and once for `b`.
- The top level holds the FSM, the counter and `cin`.

## Test plan
- **Reset:** assert `rst` mid-cycle. Expect `a` = `b` = 0, `cin` = 0, `out_valid` = 0 and `in_ready` = 1 immediately, without waiting for a clock edge.
- **Wrap case:**
  - Stimulus: A beats 0xFFFFF ×5 with `in_cin` = 1 on the first beat, then B beats 0x00001, 0, 0, 0, 0.
  - Expect `out_valid` one cycle after the 10th beat, with `a` = 2^100−1, `b` = 1 and `cin` = 1.
  - The adder output then reads sum = 1.
- **Ordering and gaps:** A beats 1, 2, 3, 4, 5 with random idle cycles in between. Expect `a[k*20 +: 20]` = k+1 and an unchanged cycle count per accepted beat.
- **Back-pressure:**
  - Stimulus: hold `out_ready` = 0 for 7 cycles in PRESENT while driving `in_valid` = 1.
  - Expect `in_ready` = 0 and `a`, `b`, `cin` stable throughout.
  - After `out_ready` pulses, expect `in_ready` = 1 on the next cycle.
- **Reset mid-load:** assert `rst` after 3 A beats. Expect the next 10 beats to form a fresh pair with no residue.
- **`ADD_LOADER_ABORT_EN`:**
  - Stimulus: `abort` on the same cycle as B beat 2.
  - Expect state LOAD_A, `cnt` = 0 and no `out_valid`.
  - The following 10 beats then produce a correct pair.
